// File: rtl/rs_omega_shift_seq.sv
// Sequential omega-polynomial shifter for the RS decoder back end: accepts one
// T2-symbol omega vector, shifts it down STEP symbols per enabled cycle and presents the low OUT_N.
module rs_omega_shift_seq #(
    parameter int SYM_W   = 8,
    parameter int T2      = 16,
    parameter int OUT_N   = 8,
    parameter int SHIFT_W = 5,
    parameter int STEP    = 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [T2*SYM_W-1:0]      omega_in,
    input  logic [SHIFT_W-1:0]       numShifted,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_N*SYM_W-1:0]   omegaShifted,
    output logic                     shift_err
);

    localparam int MIN_SH = T2 - OUT_N;
    localparam logic [SHIFT_W-1:0] STEP_W = SHIFT_W'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                 state_r;
    logic [T2*SYM_W-1:0]    win_r;
    logic [SHIFT_W-1:0]     rem_r;
    logic                   err_r;

    logic [T2*SYM_W-1:0]    winShifted_s;
    logic [SHIFT_W-1:0]     shAmt_s;
    logic                   lastShift_s;
    logic                   inRange_s;

    // Move every symbol down by amt positions, zero-filling the vacated top symbols.
    function automatic logic [T2*SYM_W-1:0] shiftDown(input logic [T2*SYM_W-1:0] w,
                                                      input logic [SHIFT_W-1:0]  amt);
        logic [T2*SYM_W-1:0] res;
        res = '0;
        for (int k = 0; k < T2; k++) begin
            if (k + int'(amt) < T2) begin
                res[k*SYM_W +: SYM_W] = w[(k + int'(amt))*SYM_W +: SYM_W];
            end else begin
                res[k*SYM_W +: SYM_W] = {SYM_W{1'b0}};
            end
        end
        return res;
    endfunction

    // Range check of the incoming shift and the size of this cycle's shift step.
    always_comb begin
        inRange_s    = (int'(numShifted) >= MIN_SH) && (int'(numShifted) <= T2 - 1);
        lastShift_s  = (int'(rem_r) <= STEP);
        if (lastShift_s) begin
            shAmt_s = rem_r;
        end else begin
            shAmt_s = STEP_W;
        end
        winShifted_s = shiftDown(win_r, shAmt_s);
    end

    // Control FSM with registered handshake and result outputs; enable freezes everything.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r      <= ST_IDLE;
            win_r        <= '0;
            rem_r        <= '0;
            err_r        <= 1'b0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            omegaShifted <= '0;
            shift_err    <= 1'b0;
        end else if (enable) begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (inRange_s) begin
                            win_r   <= omega_in;
                            rem_r   <= numShifted;
                            err_r   <= 1'b0;
                            state_r <= ST_SHIFT;
                        end else begin
                            // Bad shift amount: skip shifting and report an all-zero result.
                            win_r        <= '0;
                            rem_r        <= '0;
                            err_r        <= 1'b1;
                            state_r      <= ST_HOLD;
                            out_valid    <= 1'b1;
                            omegaShifted <= '0;
                            shift_err    <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    win_r <= winShifted_s;
                    if (lastShift_s) begin
                        rem_r        <= '0;
                        state_r      <= ST_HOLD;
                        out_valid    <= 1'b1;
                        omegaShifted <= winShifted_s[OUT_N*SYM_W-1:0];
                        shift_err    <= err_r;
                    end else begin
                        rem_r <= rem_r - STEP_W;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_r      <= ST_IDLE;
                        in_ready     <= 1'b1;
                        out_valid    <= 1'b0;
                        omegaShifted <= '0;
                        shift_err    <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    in_ready     <= 1'b1;
                    out_valid    <= 1'b0;
                    omegaShifted <= '0;
                    shift_err    <= 1'b0;
                end
            endcase
        end
    end

endmodule
